branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, legal range 8..64.
REQ-002 SHALL have parameter CNT_W, default 16: width of each statistics counter, legal range 4..32.
REQ-003 SHALL have parameter PIPE, default 1: number of register stages from input to output, 1 or 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: a branch compare request is present.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: compare operands.
REQ-008 SHALL have port op, input, 4 bits: compare operation.
REQ-009 SHALL have port pred_taken, input, 1 bit: the fetch stage's prediction for this branch.
REQ-010 SHALL have port stall, input, 1 bit: hold all pipeline state.
REQ-011 SHALL have port flush, input, 1 bit: kill all in-flight requests.
REQ-012 SHALL have port clr_cnt, input, 1 bit: zero the statistics counters.
REQ-013 SHALL have port out_valid, output, 1 bit: br and mispredict are valid.
REQ-014 SHALL have port br, output, 1 bit: branch is taken.
REQ-015 SHALL have port mispredict, output, 1 bit: br differs from the registered pred_taken.
REQ-016 SHALL have ports cnt_branch, cnt_taken and cnt_mispred, output, CNT_W bits each: count of resolved branches, taken branches and mispredicted branches.

Function
REQ-017 SHALL encode op as follows:
- 0 EQ: a==b
- 1 NE: a!=b
- 2 LEZ: a<=0 signed
- 3 GTZ: a>0 signed
- 4 LTZ: a<0 signed
- 5 GEZ: a>=0 signed
- 6 LT: a<b signed
- 7 LTU: a<b unsigned
- 8 GE: a>=b signed
- 9 GEU: a>=b unsigned
- 10..15: br=0
REQ-018 SHALL compute signed compares exactly, with no overflow error: a=0x7FFFFFFF, b=0x80000000, op LT gives br=0.
REQ-019 SHALL ignore b for ops 2..5.
REQ-020 SHALL, for PIPE=1, register the result and pred_taken on the edge that samples in_valid=1, so out_valid rises 1 cycle later.
REQ-021 SHALL, for PIPE=2, register a, b, op, pred_taken and in_valid in stage 1 and evaluate into the output register in stage 2, giving a latency of 2 cycles.
REQ-022 SHALL, for either PIPE value, accept one request per cycle when not stalled, at full throughput.
REQ-023 SHALL, while stall=1 and flush=0, hold every pipeline register, every output and every counter; inputs presented during that cycle are not captured.
REQ-024 SHALL, when flush=1, clear every stage valid bit on the next edge, so out_valid=0 the cycle after flush.
REQ-025 SHALL give flush priority over stall.
REQ-026 SHALL discard a request presented with in_valid=1 in the flush cycle.
REQ-027 SHALL drive br=0 and mispredict=0 whenever out_valid=0.
REQ-028 SHALL increment the counters on each edge that loads a valid result into the output register, with no stall and no flush:
- cnt_branch +1
- cnt_taken +1 if br
- cnt_mispred +1 if mispredict
REQ-029 SHALL saturate each counter at all-ones, with no wrap-around.
REQ-030 SHALL zero all three counters on the next edge when clr_cnt=1, with clr_cnt overriding a simultaneous increment and overriding stall.

Reset
REQ-031 SHALL, on the rising edge with rst_n=0, clear all valid bits, out_valid, br, mispredict and all counters to 0, regardless of stall, flush or clr_cnt.
REQ-032 SHALL discard any request in flight when reset is applied mid-operation; there is no out_valid for it after reset is released.
REQ-033 SHALL leave datapath-only registers (operands, op) unconstrained by reset.

Verification
REQ-034 SHALL be covered by: PIPE=1, in_valid=1, a=5, b=5, op=EQ, pred_taken=0 -> next cycle out_valid=1, br=1, mispredict=1, cnt_branch=1, cnt_taken=1, cnt_mispred=1.
REQ-035 SHALL be covered by: op=LT with a=0xFFFFFFFF, b=1 -> br=1; op=LTU with the same a and b -> br=0; op=GEZ with a=0 -> br=1; op=12 -> br=0, counted in cnt_branch.
REQ-036 SHALL be covered by: PIPE=2, back-to-back requests over 3 cycles with stall=1 held 2 cycles mid-stream -> results emerge in order, nothing lost or duplicated, counters frozen during the stall.
REQ-037 SHALL be covered by: flush=1 together with stall=1 while 2 requests are in flight with PIPE=2 -> out_valid=0 for the following 2 cycles and counters unchanged.
REQ-038 SHALL be covered by: CNT_W=4, 17 taken branches -> cnt_taken=15; then clr_cnt=1 in the same cycle as a valid result -> all counters 0.
REQ-039 SHALL be covered by: rst_n=0 for 1 cycle while a request is in stage 1 -> out_valid stays 0 and counters read 0 afterwards.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch condition resolver: evaluates a compare, flags a mispredict against the
// fetch prediction, and keeps saturating branch statistics. 1- or 2-stage pipeline.
module branch_resolve_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             pred_taken,
    input  logic             stall,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic             br,
    output logic             mispredict,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_mispred
);

    typedef enum logic [3:0] {
        OP_EQ  = 4'd0,
        OP_NE  = 4'd1,
        OP_LEZ = 4'd2,
        OP_GTZ = 4'd3,
        OP_LTZ = 4'd4,
        OP_GEZ = 4'd5,
        OP_LT  = 4'd6,
        OP_LTU = 4'd7,
        OP_GE  = 4'd8,
        OP_GEU = 4'd9
    } op_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Request as seen by the compare logic: the raw inputs for PIPE=1,
    // the stage-1 registers for PIPE=2.
    logic             ev_valid;
    logic [WIDTH-1:0] ev_a;
    logic [WIDTH-1:0] ev_b;
    logic [3:0]       ev_op;
    logic             ev_pred;

    generate
        if (PIPE == 2) begin : g_pipe2
            logic             s1_valid;
            logic [WIDTH-1:0] s1_a;
            logic [WIDTH-1:0] s1_b;
            logic [3:0]       s1_op;
            logic             s1_pred;

            // NOTE: sequential state is assigned with <= so every register samples
            // the pre-edge value of its neighbours, independent of statement order.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                end else if (flush) begin
                    s1_valid <= 1'b0;
                end else if (!stall) begin
                    s1_valid <= in_valid;
                end
            end

            // NOTE: operand/op/prediction registers carry no reset; they are only
            // meaningful while s1_valid is set, and leaving them unreset keeps
            // the reset net off the wide datapath.
            always_ff @(posedge clk) begin
                if (!stall) begin
                    s1_a    <= a;
                    s1_b    <= b;
                    s1_op   <= op;
                    s1_pred <= pred_taken;
                end
            end

            assign ev_valid = s1_valid;
            assign ev_a     = s1_a;
            assign ev_b     = s1_b;
            assign ev_op    = s1_op;
            assign ev_pred  = s1_pred;
        end else begin : g_pipe1
            assign ev_valid = in_valid;
            assign ev_a     = a;
            assign ev_b     = b;
            assign ev_op    = op;
            assign ev_pred  = pred_taken;
        end
    endgenerate

    // Compare primitives. Signed less-than uses $signed on both sides, so the
    // 0x7FFFFFFF vs 0x80000000 case is exact with no subtract-overflow hazard.
    logic eq;
    logic lt_s;
    logic lt_u;
    logic a_neg;
    logic a_zero;
    logic br_next;

    assign eq     = (ev_a == ev_b);
    assign lt_s   = ($signed(ev_a) < $signed(ev_b));
    assign lt_u   = (ev_a < ev_b);
    assign a_neg  = ev_a[WIDTH-1];
    assign a_zero = (ev_a == '0);

    // NOTE: br_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        br_next = 1'b0;
        case (op_e'(ev_op))
            OP_EQ:   br_next = eq;
            OP_NE:   br_next = !eq;
            OP_LEZ:  br_next = a_neg || a_zero;
            OP_GTZ:  br_next = !a_neg && !a_zero;
            OP_LTZ:  br_next = a_neg;
            OP_GEZ:  br_next = !a_neg;
            OP_LT:   br_next = lt_s;
            OP_LTU:  br_next = lt_u;
            OP_GE:   br_next = !lt_s;
            OP_GEU:  br_next = !lt_u;
            default: br_next = 1'b0;
        endcase
    end

    logic mis_next;
    logic load;

    assign mis_next = br_next ^ ev_pred;
    assign load     = ev_valid && !stall && !flush;

    // br/mispredict are forced low whenever the loaded slot is empty.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            out_valid  <= 1'b0;
            br         <= 1'b0;
            mispredict <= 1'b0;
        end else if (!stall) begin
            out_valid  <= ev_valid;
            br         <= ev_valid && br_next;
            mispredict <= ev_valid && mis_next;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic             en);
        return (en && (c != CNT_MAX)) ? c + CNT_ONE : c;
    endfunction

    // clr_cnt outranks both the increment and stall.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            cnt_branch  <= '0;
            cnt_taken   <= '0;
            cnt_mispred <= '0;
        end else if (load) begin
            cnt_branch  <= sat_inc(cnt_branch, 1'b1);
            cnt_taken   <= sat_inc(cnt_taken, br_next);
            cnt_mispred <= sat_inc(cnt_mispred, mis_next);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: three instances (PIPE=1, PIPE=2,
// PIPE=1 with 4-bit counters) driven by the same stimulus.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic br;
        logic mp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, pred_taken, stall, flush, clr_cnt;
    logic [31:0] a, b;
    logic [3:0]  op;

    logic        ov0, br0, mp0, ov1, br1, mp1, ov2, br2, mp2;
    logic [15:0] cb0, ct0, cm0, cb1, ct1, cm1;
    logic [3:0]  cb2, ct2, cm2;

    exp_t q[3][$];
    int   ecb[3];
    int   ect[3];
    int   ecm[3];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.WIDTH(32), .CNT_W(16), .PIPE(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op(op),
        .pred_taken(pred_taken), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .out_valid(ov0), .br(br0), .mispredict(mp0),
        .cnt_branch(cb0), .cnt_taken(ct0), .cnt_mispred(cm0));

    branch_resolve_unit #(.WIDTH(32), .CNT_W(16), .PIPE(2)) u_p2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op(op),
        .pred_taken(pred_taken), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .out_valid(ov1), .br(br1), .mispredict(mp1),
        .cnt_branch(cb1), .cnt_taken(ct1), .cnt_mispred(cm1));

    branch_resolve_unit #(.WIDTH(32), .CNT_W(4), .PIPE(1)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .op(op),
        .pred_taken(pred_taken), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .out_valid(ov2), .br(br2), .mispredict(mp2),
        .cnt_branch(cb2), .cnt_taken(ct2), .cnt_mispred(cm2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference compare, computed on 64-bit sign/zero-extended operands.
    function automatic logic ref_br(input logic [31:0] xa, input logic [31:0] xb,
                                    input logic [3:0] xop);
        longint sa, sb, ua, ub;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        ua = longint'({32'd0, xa});
        ub = longint'({32'd0, xb});
        case (xop)
            4'd0:    return sa == sb;
            4'd1:    return sa != sb;
            4'd2:    return sa <= 0;
            4'd3:    return sa > 0;
            4'd4:    return sa < 0;
            4'd5:    return sa >= 0;
            4'd6:    return sa < sb;
            4'd7:    return ua < ub;
            4'd8:    return sa >= sb;
            4'd9:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of inputs; push the expected result if it will be captured.
    task automatic step(input logic iv, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [3:0] xop, input logic xp, input logic xs = 1'b0,
                        input logic xf = 1'b0, input logic xc = 1'b0, input logic xr = 1'b1);
        exp_t e;
        in_valid   = iv;
        a          = xa;
        b          = xb;
        op         = xop;
        pred_taken = xp;
        stall      = xs;
        flush      = xf;
        clr_cnt    = xc;
        rst_n      = xr;
        if (iv && !xs && !xf && xr) begin
            e.br = ref_br(xa, xb, xop);
            e.mp = e.br ^ xp;
            for (int k = 0; k < 3; k++) q[k].push_back(e);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    endtask

    // Runs on the falling edge; inputs still hold the values sampled at the rising edge.
    task automatic mon(input int k, input logic ov, input logic obr, input logic omp,
                       input logic [31:0] cb, input logic [31:0] ct, input logic [31:0] cm,
                       input int cw);
        exp_t e;
        int   mx;
        mx = (1 << cw) - 1;
        if (!rst_n) begin
            q[k].delete();
            ecb[k] = 0; ect[k] = 0; ecm[k] = 0;
            check($sformatf("d%0d_rst_ov", k), ov, 0);
        end else begin
            if (flush) begin
                q[k].delete();
                check($sformatf("d%0d_flush_ov", k), ov, 0);
            end else if (!stall && ov) begin
                if (q[k].size() == 0) begin
                    check($sformatf("d%0d_spurious_ov", k), ov, 0);
                end else begin
                    e = q[k].pop_front();
                    check($sformatf("d%0d_br", k), obr, e.br);
                    check($sformatf("d%0d_mispredict", k), omp, e.mp);
                    if (ecb[k] < mx) ecb[k]++;
                    if (e.br && ect[k] < mx) ect[k]++;
                    if (e.mp && ecm[k] < mx) ecm[k]++;
                end
            end
            if (clr_cnt) begin
                ecb[k] = 0; ect[k] = 0; ecm[k] = 0;
            end
        end
        if (!ov) check($sformatf("d%0d_idle_br_mp", k), {obr, omp}, 2'b00);
        check($sformatf("d%0d_cnt_branch", k), cb, ecb[k]);
        check($sformatf("d%0d_cnt_taken", k), ct, ect[k]);
        check($sformatf("d%0d_cnt_mispred", k), cm, ecm[k]);
    endtask

    always @(negedge clk) begin
        mon(0, ov0, br0, mp0, 32'(cb0), 32'(ct0), 32'(cm0), 16);
        mon(1, ov1, br1, mp1, 32'(cb1), 32'(ct1), 32'(cm1), 16);
        mon(2, ov2, br2, mp2, 32'(cb2), 32'(ct2), 32'(cm2), 4);
    end

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 4));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb;
        // Reset with stall/flush/clr asserted to show reset wins regardless.
        step(1'b1, 32'd1, 32'd1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // EQ taken, predicted not-taken.
        step(1'b1, 32'd5, 32'd5, 4'd0, 1'b0);
        idle(2);

        // Directed compares, incl. the signed-overflow corner and reserved op.
        step(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd6, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd7, 1'b0);
        step(1'b1, 32'd0, 32'hDEAD_BEEF, 4'd5, 1'b1);
        step(1'b1, 32'd3, 32'd3, 4'd12, 1'b1);
        step(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 4'd6, 1'b1);
        step(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 4'd8, 1'b0);
        step(1'b1, 32'd7, 32'd9, 4'd1, 1'b1);
        step(1'b1, 32'd0, 32'hFFFF_FFFF, 4'd2, 1'b0);
        step(1'b1, 32'd0, 32'd1, 4'd3, 1'b0);
        step(1'b1, 32'h8000_0000, 32'd0, 4'd4, 1'b0);
        step(1'b1, 32'd1, 32'hFFFF_FFFF, 4'd9, 1'b1);
        step(1'b1, 32'd2, 32'd2, 4'd15, 1'b0);
        idle(2);

        // Back-to-back stream with a 2-cycle stall mid-stream.
        step(1'b1, 32'd1, 32'd2, 4'd6, 1'b1);
        step(1'b1, 32'd4, 32'd4, 4'd0, 1'b0);
        step(1'b1, 32'd9, 32'd9, 4'd1, 1'b1, 1'b1);
        step(1'b1, 32'd9, 32'd9, 4'd0, 1'b0, 1'b1);
        step(1'b1, 32'd8, 32'd3, 4'd9, 1'b0);
        idle(3);

        // Two in flight, then flush together with stall and a new request.
        step(1'b1, 32'd1, 32'd1, 4'd0, 1'b1);
        step(1'b1, 32'd2, 32'd1, 4'd8, 1'b0);
        step(1'b1, 32'd3, 32'd3, 4'd0, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Reset for one cycle while a request sits in stage 1.
        step(1'b1, 32'd6, 32'd6, 4'd0, 1'b0);
        step(1'b1, 32'd6, 32'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Saturation: 17 taken branches, then clear alongside a valid result.
        for (int i = 0; i < 17; i++) step(1'b1, 32'(i), 32'(i), 4'd0, 1'b1);
        step(1'b1, 32'd1, 32'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);

        // Random traffic with occasional stall, flush and counter clear.
        for (int i = 0; i < 300; i++) begin
            ra = rnd_val();
            rb = ($urandom_range(0, 3) == 0) ? ra : rnd_val();
            step($urandom_range(0, 3) != 0, ra, rb, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
        end

        idle(4);
        for (int k = 0; k < 3; k++) check($sformatf("d%0d_drain_left", k), q[k].size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
